// File: rtl/mtsp_arb_pkg.sv
// Shared types for the MTSP memory-command arbiters: FSM states, owner width
// for the default requester count, and the inter-bus command descriptor.
package mtsp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } arb_state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int OWNER_W     = $clog2(NUM_REQ_DEF);

  // Index width of the inter-bus memory command descriptor.
  localparam int CMD_IDX_W   = 12;

  typedef struct packed {
    logic                 we;
    logic [CMD_IDX_W-1:0] index;
    logic [7:0]           size;
    logic                 cache_only;
  } mtsp_cmd_t;

endpackage

// File: rtl/mtsp_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping to bit 0. Returns a one-hot grant, the winner id and a valid flag.
module mtsp_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  // Pass 0 scans ptr..N-1, pass 1 scans 0..ptr-1; first hit wins.
  always_comb begin
    gnt   = '0;
    id    = '0;
    valid = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int j = 0; j < N; j++) begin
        if (!valid && req[j] && ((pass == 0) == (j >= int'(ptr)))) begin
          valid  = 1'b1;
          gnt[j] = 1'b1;
          id     = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mtsp_mem_cmd_arbiter.sv
// Round-robin arbiter/sequencer in front of the MTSP inter-bus memory command
// descriptor. One command outstanding at a time; tracks MEM_BUSY until the
// transfer drains and reports per-requester GRANT / DONE / ERR pulses.
module mtsp_mem_cmd_arbiter
  import mtsp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = CMD_IDX_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           REQ,
  input  logic [NUM_REQ-1:0]           REQ_WE,
  input  logic [NUM_REQ*IDX_W-1:0]     REQ_INDEX,
  input  logic [NUM_REQ*8-1:0]         REQ_SIZE,
  input  logic [NUM_REQ-1:0]           REQ_CACHE_ONLY,
  output logic [NUM_REQ-1:0]           GRANT,
  output logic [NUM_REQ-1:0]           DONE,
  output logic [NUM_REQ-1:0]           ERR,
  output logic                         CMD_REQ,
  output logic                         CMD_WE,
  output logic [IDX_W-1:0]             CMD_INDEX,
  output logic [7:0]                   CMD_SIZE,
  output logic                         CMD_CACHE_ONLY,
  input  logic                         MEM_BUSY,
  output logic [$clog2(NUM_REQ)-1:0]   OWNER,
  output logic                         ACTIVE
);

  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  arb_state_t         state_p0;
  logic [OWN_W-1:0]   ptr_p0;
  logic [WD_W-1:0]    wd_p0;
  logic [NUM_REQ-1:0] own_vec_p0;
  logic               zero_p0;
  mtsp_cmd_t          cmd_p0;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [OWN_W-1:0]   pick_id;
  logic               pick_valid;
  mtsp_cmd_t          win_cmd;

  mtsp_rr_pick #(
    .N    (NUM_REQ),
    .ID_W (OWN_W)
  ) u_pick (
    .req   (REQ),
    .ptr   (ptr_p0),
    .gnt   (pick_gnt),
    .id    (pick_id),
    .valid (pick_valid)
  );

  // Mux the winning requester's descriptor fields (one-hot AND-OR select).
  always_comb begin
    win_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        win_cmd.we         = REQ_WE[i];
        win_cmd.index      = CMD_IDX_W'(REQ_INDEX[i*IDX_W +: IDX_W]);
        win_cmd.size       = REQ_SIZE[i*8 +: 8];
        win_cmd.cache_only = REQ_CACHE_ONLY[i];
      end
    end
  end

  assign CMD_WE         = cmd_p0.we;
  assign CMD_INDEX      = IDX_W'(cmd_p0.index);
  assign CMD_SIZE       = cmd_p0.size;
  assign CMD_CACHE_ONLY = cmd_p0.cache_only;

  // Arbitration FSM; every output is a register updated on the transition.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_p0   <= IDLE;
      ptr_p0     <= '0;
      wd_p0      <= '0;
      own_vec_p0 <= '0;
      zero_p0    <= 1'b0;
      cmd_p0     <= '0;
      GRANT      <= '0;
      DONE       <= '0;
      ERR        <= '0;
      CMD_REQ    <= 1'b0;
      OWNER      <= '0;
      ACTIVE     <= 1'b0;
    end else begin
      GRANT   <= '0;
      DONE    <= '0;
      ERR     <= '0;
      CMD_REQ <= 1'b0;
      case (state_p0)
        IDLE: begin
          // Foreign or stale inter-bus activity blocks issue until it clears.
          if (pick_valid && !MEM_BUSY) begin
            GRANT      <= pick_gnt;
            OWNER      <= pick_id;
            own_vec_p0 <= pick_gnt;
            cmd_p0     <= win_cmd;
            wd_p0      <= '0;
            ACTIVE     <= 1'b1;
            if (win_cmd.size == 8'd0) begin
              // Nothing to move: skip the descriptor, complete from FINISH.
              zero_p0  <= 1'b1;
              state_p0 <= FINISH;
            end else begin
              zero_p0  <= 1'b0;
              CMD_REQ  <= 1'b1;
              state_p0 <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state_p0 <= WAIT;
        end
        WAIT: begin
          // MEM_BUSY is registered upstream, so it is already high here.
          if (!MEM_BUSY) begin
            DONE     <= own_vec_p0;
            state_p0 <= FINISH;
          end else if (WD_EN && (wd_p0 == WD_LAST)) begin
            ERR      <= own_vec_p0;
            state_p0 <= FINISH;
          end else begin
            wd_p0 <= wd_p0 + WD_W'(1);
          end
        end
        FINISH: begin
          if (zero_p0) begin
            DONE <= own_vec_p0;
          end
          zero_p0  <= 1'b0;
          ptr_p0   <= (OWNER == OWN_W'(NUM_REQ - 1)) ? '0 : OWNER + OWN_W'(1);
          ACTIVE   <= 1'b0;
          state_p0 <= IDLE;
        end
        default: begin
          state_p0 <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mtsp_mem_cmd_arbiter.sv
// Directed bench for mtsp_mem_cmd_arbiter with a simple inter-bus busy model.
module tb_mtsp_mem_cmd_arbiter;

  localparam int NR = 4;
  localparam int IW = 12;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_we;
  logic [NR*IW-1:0]  req_index;
  logic [NR*8-1:0]   req_size;
  logic [NR-1:0]     req_co;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic [NR-1:0]     err;
  logic              cmd_req;
  logic              cmd_we;
  logic [IW-1:0]     cmd_index;
  logic [7:0]        cmd_size;
  logic              cmd_co;
  logic              mem_busy;
  logic [1:0]        owner;
  logic              active;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   busy_len     = 0;
  int   busy_cnt     = 0;
  logic busy_force   = 1'b0;

  mtsp_mem_cmd_arbiter #(
    .NUM_REQ (NR),
    .IDX_W   (IW),
    .TIMEOUT (TO)
  ) dut (
    .CLK            (clk),
    .RST            (rst),
    .REQ            (req),
    .REQ_WE         (req_we),
    .REQ_INDEX      (req_index),
    .REQ_SIZE       (req_size),
    .REQ_CACHE_ONLY (req_co),
    .GRANT          (grant),
    .DONE           (done),
    .ERR            (err),
    .CMD_REQ        (cmd_req),
    .CMD_WE         (cmd_we),
    .CMD_INDEX      (cmd_index),
    .CMD_SIZE       (cmd_size),
    .CMD_CACHE_ONLY (cmd_co),
    .MEM_BUSY       (mem_busy),
    .OWNER          (owner),
    .ACTIVE         (active)
  );

  always #5 clk = ~clk;

  // Inter-bus busy model: a descriptor strobe raises busy for busy_len cycles.
  initial begin
    mem_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1)       busy_cnt = 0;
      else if (cmd_req)       busy_cnt = busy_len;
      else if (busy_cnt > 0)  busy_cnt = busy_cnt - 1;
      mem_busy = busy_force || (busy_cnt > 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [IW-1:0] idx,
                         input logic [7:0] sz, input logic co);
    req_we[i]               = we;
    req_index[i*IW +: IW]   = idx;
    req_size[i*8 +: 8]      = sz;
    req_co[i]               = co;
  endtask

  task automatic wait_grant(output logic [NR-1:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (grant !== '0) begin
        g  = grant;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (active === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0; req_we = '0; req_index = '0; req_size = '0; req_co = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({grant, done, err, cmd_req, cmd_we, cmd_index, cmd_size, cmd_co, owner, active} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: grant=%b done=%b err=%b cmd_req=%b idx=%h owner=%0d active=%b, required all 0",
               grant, done, err, cmd_req, cmd_index, owner, active);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (active !== 1'b0 || grant !== '0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: active=%b grant=%b, required 0/0000", active, grant);
    end
  endtask

  task automatic test_single();
    set_req(0, 1'b0, 12'h010, 8'd8, 1'b0);
    busy_len = 9;
    req = 4'b0001;
    tick();
    tests_run++;
    if (cmd_req !== 1'b1 || grant !== 4'b0001) begin
      tests_failed++;
      $display("FAIL single_issue: cmd_req=%b grant=%b, required 1/0001", cmd_req, grant);
    end
    tests_run++;
    if (cmd_index !== 12'h010 || cmd_size !== 8'd8 || cmd_we !== 1'b0 || owner !== 2'd0 || active !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_fields: idx=%h size=%0d we=%b owner=%0d active=%b, required 010/8/0/0/1",
               cmd_index, cmd_size, cmd_we, owner, active);
    end
    req = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      tests_run++;
      if (done !== ((k == 10) ? 4'b0001 : 4'b0000) || cmd_req !== 1'b0 || grant !== 4'b0000) begin
        tests_failed++;
        $display("FAIL single_done_c%0d: done=%b cmd_req=%b grant=%b, required done=%b cmd_req=0 grant=0000",
                 k, done, cmd_req, grant, (k == 10) ? 4'b0001 : 4'b0000);
      end
    end
    tests_run++;
    if (active !== 1'b0 || cmd_index !== 12'h010) begin
      tests_failed++;
      $display("FAIL single_after: active=%b idx=%h, required 0/010", active, cmd_index);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_seq [5];
    logic [IW-1:0] exp_idx [5];
    int   n;
    logic bb;
    bit   ok;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_idx = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h100};
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 12'h100 + IW'(i), 8'd2, 1'b0);
    busy_len = 2;
    req = 4'b1111;
    n = 0;
    for (int cyc = 0; cyc < 80 && n < 5; cyc++) begin
      @(negedge clk);
      #1 bb = mem_busy;
      tick();
      if (cmd_req === 1'b1) begin
        tests_run++;
        if (bb !== 1'b0) begin
          tests_failed++;
          $display("FAIL rr_issue_while_busy: cmd_req=1 with mem_busy=%b, required mem_busy=0", bb);
        end
      end
      if (grant !== '0) begin
        tests_run++;
        if (grant !== exp_seq[n] || cmd_req !== 1'b1 || cmd_index !== exp_idx[n]) begin
          tests_failed++;
          $display("FAIL rr_grant_%0d: grant=%b cmd_req=%b idx=%h, required %b/1/%h",
                   n, grant, cmd_req, cmd_index, exp_seq[n], exp_idx[n]);
        end
        n++;
      end
    end
    req = '0;
    tests_run++;
    if (n != 5) begin
      tests_failed++;
      $display("FAIL rr_count: grants=%0d, required 5", n);
    end
    wait_idle(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rr_drain: active=%b, required 0 within bound", active);
    end
  endtask

  task automatic test_wrap();
    logic [NR-1:0] g;
    bit ok;
    set_req(3, 1'b1, 12'h3A5, 8'd3, 1'b1);
    set_req(0, 1'b0, 12'h001, 8'd3, 1'b0);
    busy_len = 1;
    req = 4'b1000;
    tick();
    tests_run++;
    if (grant !== 4'b1000 || owner !== 2'd3 || cmd_we !== 1'b1 || cmd_co !== 1'b1 || cmd_index !== 12'h3A5) begin
      tests_failed++;
      $display("FAIL wrap_owner3: grant=%b owner=%0d we=%b co=%b idx=%h, required 1000/3/1/1/3a5",
               grant, owner, cmd_we, cmd_co, cmd_index);
    end
    req = '0;
    wait_idle(ok);
    req = 4'b1001;
    wait_grant(g, ok);
    tests_run++;
    if (!ok || g !== 4'b0001) begin
      tests_failed++;
      $display("FAIL wrap_first: grant=%b seen=%0d, required 0001", g, ok);
    end
    wait_grant(g, ok);
    req = '0;
    tests_run++;
    if (!ok || g !== 4'b1000) begin
      tests_failed++;
      $display("FAIL wrap_second: grant=%b seen=%0d, required 1000", g, ok);
    end
    wait_idle(ok);
  endtask

  task automatic test_zero_size();
    set_req(2, 1'b0, 12'h222, 8'd0, 1'b0);
    req = 4'b0100;
    tick();
    tests_run++;
    if (grant !== 4'b0100 || cmd_req !== 1'b0 || done !== 4'b0000 || active !== 1'b1 || cmd_size !== 8'd0) begin
      tests_failed++;
      $display("FAIL zero_grant: grant=%b cmd_req=%b done=%b active=%b size=%0d, required 0100/0/0000/1/0",
               grant, cmd_req, done, active, cmd_size);
    end
    req = '0;
    tick();
    tests_run++;
    if (done !== 4'b0100 || grant !== 4'b0000 || cmd_req !== 1'b0 || active !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_done: done=%b grant=%b cmd_req=%b active=%b, required 0100/0000/0/0",
               done, grant, cmd_req, active);
    end
    tick();
    tests_run++;
    if (done !== 4'b0000 || cmd_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_after: done=%b cmd_req=%b, required 0000/0", done, cmd_req);
    end
  endtask

  task automatic test_busy_block();
    bit ok;
    busy_force = 1'b1;
    tick();
    set_req(0, 1'b0, 12'h0C0, 8'd1, 1'b0);
    busy_len = 1;
    req = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      tests_run++;
      if (grant !== 4'b0000 || cmd_req !== 1'b0 || active !== 1'b0) begin
        tests_failed++;
        $display("FAIL busy_block_c%0d: grant=%b cmd_req=%b active=%b, required 0000/0/0",
                 k, grant, cmd_req, active);
      end
    end
    busy_force = 1'b0;
    tick();
    tests_run++;
    if (grant !== 4'b0001 || cmd_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_release: grant=%b cmd_req=%b, required 0001/1", grant, cmd_req);
    end
    req = '0;
    wait_idle(ok);
  endtask

  task automatic test_timeout();
    set_req(1, 1'b1, 12'h0AB, 8'd5, 1'b0);
    busy_len = 0;
    req = 4'b0010;
    tick();
    tests_run++;
    if (grant !== 4'b0010 || cmd_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_issue: grant=%b cmd_req=%b, required 0010/1", grant, cmd_req);
    end
    req = '0;
    busy_force = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      tests_run++;
      if (err !== ((k == 17) ? 4'b0010 : 4'b0000) || done !== 4'b0000) begin
        tests_failed++;
        $display("FAIL timeout_c%0d: err=%b done=%b, required err=%b done=0000",
                 k, err, done, (k == 17) ? 4'b0010 : 4'b0000);
      end
    end
    tests_run++;
    if (active !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_idle: active=%b, required 0", active);
    end
    busy_force = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] g;
    bit ok;
    set_req(1, 1'b0, 12'h155, 8'd4, 1'b0);
    busy_len = 20;
    req = 4'b0010;
    tick();
    tests_run++;
    if (grant !== 4'b0010) begin
      tests_failed++;
      $display("FAIL rstmid_grant: grant=%b, required 0010", grant);
    end
    req = '0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({grant, done, err, cmd_req, cmd_we, cmd_index, cmd_size, cmd_co, owner, active} !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: grant=%b done=%b err=%b cmd_req=%b idx=%h size=%0d owner=%0d active=%b, required all 0",
               grant, done, err, cmd_req, cmd_index, cmd_size, owner, active);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests_run++;
      if (done !== 4'b0000 || err !== 4'b0000 || active !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstmid_silent_c%0d: done=%b err=%b active=%b, required 0000/0000/0",
                 k, done, err, active);
      end
    end
    set_req(1, 1'b0, 12'h011, 8'd1, 1'b0);
    set_req(2, 1'b1, 12'h022, 8'd1, 1'b0);
    busy_len = 1;
    req = 4'b0110;
    tick();
    tests_run++;
    if (grant !== 4'b0010 || owner !== 2'd1) begin
      tests_failed++;
      $display("FAIL rstmid_ptr0: grant=%b owner=%0d, required 0010/1", grant, owner);
    end
    req = 4'b0100;
    wait_grant(g, ok);
    req = '0;
    tests_run++;
    if (!ok || g !== 4'b0100 || owner !== 2'd2 || cmd_index !== 12'h022) begin
      tests_failed++;
      $display("FAIL rstmid_req2: grant=%b owner=%0d idx=%h seen=%0d, required 0100/2/022",
               g, owner, cmd_index, ok);
    end
    wait_idle(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rstmid_drain: active=%b, required 0 within bound", active);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_zero_size();
    test_busy_block();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
